// File: rtl/regwb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the issue/decode stages and the
// register-file write port.
//   slave  : the arbiter side (takes requests, drives grants, write port, scoreboard)
//   master : the requester / pipeline side
// Signals:
//   alu_valid/alu_ready, alu_reg[4:0], alu_data[31:0]  ALU writeback handshake
//   mem_valid/mem_ready, mem_reg[4:0], mem_data[31:0]  load writeback handshake
//   pend_set, pend_reg[4:0]                            in-flight destination mark
//   ReadRegister1/2[4:0]                               decode source registers
//   RegWrite, WriteRegister[4:0], WriteData_reg[31:0]  register-file write port
//   pending[31:0], hazard                              scoreboard and hazard flag
interface regwb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        pend_set;
    logic [4:0]  pend_reg;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData_reg;
    logic [31:0] pending;
    logic        hazard;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  pend_set, pend_reg, ReadRegister1, ReadRegister2,
        output alu_ready, mem_ready,
        output RegWrite, WriteRegister, WriteData_reg, pending, hazard
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output pend_set, pend_reg, ReadRegister1, ReadRegister2,
        input  alu_ready, mem_ready,
        input  RegWrite, WriteRegister, WriteData_reg, pending, hazard
    );
endinterface

// File: rtl/regwb_arbiter.sv
// Register-file writeback arbiter with scoreboard.
// Two requesters (ALU, load) share a single register-file write port. Grants are
// round-robin when both request; after STARVE_LIMIT back-to-back grants one cycle
// is forced idle so the register file gets a read slot. Accepted writes appear on
// the write port one cycle later. A 32-entry pending scoreboard tracks in-flight
// destinations and flags decode-stage hazards.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    regwb_arbiter_if.slave (handshakes, write port, scoreboard, hazard)
module regwb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clock,
    input logic           reset,
    regwb_arbiter_if.slave bus
);

    localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] Limit = StreakW'(STARVE_LIMIT);

    typedef enum logic {
        GrantAlu = 1'b0,
        GrantMem = 1'b1
    } grant_e;

    grant_e              last_grant_q, last_grant_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                regwrite_q, regwrite_d;
    logic [4:0]          wreg_q, wreg_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         pending_q, pending_d;

    logic        allow;
    logic        alu_grant, mem_grant;
    logic        accept;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    // Grant decision. Readiness is forced low during reset so nothing is accepted
    // while state is being cleared.
    always_comb begin
        allow     = !reset && (streak_q < Limit);
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (allow) begin
            if (bus.alu_valid && bus.mem_valid) begin
                // Both waiting: give it to whoever was not served last.
                mem_grant = (last_grant_q == GrantAlu);
                alu_grant = (last_grant_q == GrantMem);
            end else begin
                alu_grant = bus.alu_valid;
                mem_grant = bus.mem_valid;
            end
        end
        accept   = alu_grant || mem_grant;
        sel_reg  = mem_grant ? bus.mem_reg  : bus.alu_reg;
        sel_data = mem_grant ? bus.mem_data : bus.alu_data;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        streak_d     = '0;
        regwrite_d   = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        pending_d    = pending_q;

        if (accept) begin
            last_grant_d = mem_grant ? GrantMem : GrantAlu;
            streak_d     = streak_q + StreakW'(1);
            // r0 writes still consume a slot but never strobe the register file.
            regwrite_d   = (sel_reg != 5'd0);
            wreg_d       = sel_reg;
            wdata_d      = sel_data;
            pending_d[sel_reg] = 1'b0;
        end
        // Applied after the clear: a new producer for the same register wins.
        if (bus.pend_set) begin
            pending_d[bus.pend_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= GrantAlu;
            streak_q     <= '0;
            regwrite_q   <= 1'b0;
            wreg_q       <= 5'd0;
            wdata_q      <= 32'd0;
            pending_q    <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            streak_q     <= streak_d;
            regwrite_q   <= regwrite_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.alu_ready     = alu_grant;
    assign bus.mem_ready     = mem_grant;
    assign bus.RegWrite      = regwrite_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData_reg = wdata_q;
    assign bus.pending       = pending_q;
    assign bus.hazard        = pending_q[bus.ReadRegister1] | pending_q[bus.ReadRegister2];

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter (STARVE_LIMIT = 4). Inputs change 1 time unit
// after the rising edge; outputs are sampled 2 units after the edge.
module tb_regwb_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    regwb_arbiter_if bus();

    regwb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_reg = 5'd0; bus.alu_data = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_reg = 5'd0; bus.mem_data = 32'd0;
        bus.pend_set = 1'b0;  bus.pend_reg = 5'd0;
        bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        reset = 1'b1;
        step(); #1;
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL reset_regwrite got %b exp 0", bus.RegWrite);
        end
        vectors++;
        if (bus.WriteRegister !== 5'd0 || bus.WriteData_reg !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_wport got %0d/%h exp 0/0", bus.WriteRegister, bus.WriteData_reg);
        end
        vectors++;
        if (bus.pending !== 32'd0 || bus.hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending got %h/%b exp 0/0", bus.pending, bus.hazard);
        end
        vectors++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got %b%b exp 00", bus.alu_ready, bus.mem_ready);
        end
    endtask

    // Both requesters held: mem, alu, mem, alu, then the forced idle slot.
    task automatic test_round_robin();
        logic       exp_mem;
        logic [4:0] exp_reg;
        logic [31:0] exp_data;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hAAAA_0001;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd6; bus.mem_data = 32'h5555_0002;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_mem  = (k % 2 == 0);
            exp_reg  = exp_mem ? 5'd6 : 5'd5;
            exp_data = exp_mem ? 32'h5555_0002 : 32'hAAAA_0001;
            vectors++;
            if (k < 4) begin
                if (bus.mem_ready !== exp_mem || bus.alu_ready !== !exp_mem) begin
                    miscompares++;
                    $display("FAIL rr_grant[%0d] got alu=%b mem=%b exp alu=%b mem=%b",
                             k, bus.alu_ready, bus.mem_ready, !exp_mem, exp_mem);
                end
            end else if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_idle_slot got alu=%b mem=%b exp 0 0",
                         bus.alu_ready, bus.mem_ready);
            end
            step(); #1;
            vectors++;
            if (k < 4) begin
                if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== exp_reg ||
                    bus.WriteData_reg !== exp_data) begin
                    miscompares++;
                    $display("FAIL rr_write[%0d] got %b r%0d=%h exp 1 r%0d=%h", k,
                             bus.RegWrite, bus.WriteRegister, bus.WriteData_reg,
                             exp_reg, exp_data);
                end
            end else if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd5) begin
                miscompares++;
                $display("FAIL rr_idle_write got %b r%0d exp 0 r5 held",
                         bus.RegWrite, bus.WriteRegister);
            end
        end
        idle_inputs();
        step();
    endtask

    // ALU alone: 4 grants, 1 forced idle, repeat; write pulses trail by one cycle.
    task automatic test_starve();
        logic exp_grant;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h0000_0033;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_grant = (k % 5 != 4);
            vectors++;
            if (bus.alu_ready !== exp_grant || bus.mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL starve_ready[%0d] got %b exp %b", k, bus.alu_ready, exp_grant);
            end
            step(); #1;
            vectors++;
            if (bus.RegWrite !== exp_grant) begin
                miscompares++;
                $display("FAIL starve_regwrite[%0d] got %b exp %b", k, bus.RegWrite, exp_grant);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reg_zero();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        bus.pend_set = 1'b1; bus.pend_reg = 5'd0;
        #1;
        vectors++;
        if (bus.alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL r0_ready got %b exp 1", bus.alu_ready);
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL r0_regwrite got %b exp 0", bus.RegWrite);
        end
        vectors++;
        if (bus.pending !== 32'd0) begin
            miscompares++; $display("FAIL r0_pending got %h exp 0", bus.pending);
        end
        step();
    endtask

    task automatic test_hazard();
        bus.pend_set = 1'b1; bus.pend_reg = 5'd17;
        step();
        bus.pend_set = 1'b0;
        bus.ReadRegister1 = 5'd17; bus.ReadRegister2 = 5'd2;
        #1;
        vectors++;
        if (bus.pending !== 32'h0002_0000 || bus.hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL hz_set got %h/%b exp 00020000/1", bus.pending, bus.hazard);
        end
        bus.ReadRegister1 = 5'd4; bus.ReadRegister2 = 5'd17;
        #1;
        vectors++;
        if (bus.hazard !== 1'b1) begin
            miscompares++; $display("FAIL hz_rs2 got %b exp 1", bus.hazard);
        end
        bus.ReadRegister2 = 5'd16;
        #1;
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++; $display("FAIL hz_clear_src got %b exp 0", bus.hazard);
        end
        bus.ReadRegister1 = 5'd17;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd17; bus.mem_data = 32'h0000_1234;
        #1;
        vectors++;
        if (bus.mem_ready !== 1'b1) begin
            miscompares++; $display("FAIL hz_mem_ready got %b exp 1", bus.mem_ready);
        end
        step();
        bus.mem_valid = 1'b0;
        #1;
        vectors++;
        if (bus.pending !== 32'd0 || bus.hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL hz_after_write got %h/%b exp 0/0", bus.pending, bus.hazard);
        end
        vectors++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd17 ||
            bus.WriteData_reg !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL hz_write got %b r%0d=%h exp 1 r17=00001234",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData_reg);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_set_wins();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h0000_0099;
        bus.pend_set = 1'b1; bus.pend_reg = 5'd9;
        #1;
        vectors++;
        if (bus.alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL sw_ready got %b exp 1", bus.alu_ready);
        end
        step();
        idle_inputs();
        bus.ReadRegister2 = 5'd9;
        #1;
        vectors++;
        if (bus.pending !== 32'h0000_0200 || bus.hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_pending got %h/%b exp 00000200/1", bus.pending, bus.hazard);
        end
        vectors++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd9 ||
            bus.WriteData_reg !== 32'h0000_0099) begin
            miscompares++;
            $display("FAIL sw_write got %b r%0d=%h exp 1 r9=00000099",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData_reg);
        end
        step();
    endtask

    // Reset lands while a write pulse is on the port and another grant is live.
    task automatic test_reset_midstream();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'h0000_0444;
        step();
        #1;
        vectors++;
        if (bus.RegWrite !== 1'b1 || bus.alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got wr=%b rdy=%b exp 1 1", bus.RegWrite, bus.alu_ready);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 ||
            bus.WriteData_reg !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_wport got %b r%0d=%h exp 0 r0=0",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData_reg);
        end
        vectors++;
        if (bus.pending !== 32'd0 || bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_state got pend=%h rdy=%b%b exp 0 00",
                     bus.pending, bus.alu_ready, bus.mem_ready);
        end
        step();
        idle_inputs();
        reset = 1'b0;
        step(); #1;
        vectors++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_no_pulse got %b r%0d exp 0 r0", bus.RegWrite, bus.WriteRegister);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_starve();
        test_reg_zero();
        test_hazard();
        test_set_wins();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
